instr_decode_stage: RTL and testbench

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

---
 rtl/instr_decode_stage_if.sv | 56 +++++
 rtl/instr_decode_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side bus of the RV32 decode stage.
// Mext/mfunct exist only when RV32M_EN is defined.
`timescale 1ns/1ps
interface instr_decode_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            RegW;
    logic            MemW;
    logic            Jal;
    logic            Jalr;
    logic            illegal;
    logic [1:0]      Memtoreg;
    logic [1:0]      ALUa;
    logic [1:0]      ALUb;
    logic [3:0]      ALU_cntr;
    logic [2:0]      Branch_cntr;
    logic [2:0]      Ld_cntr;
    logic [3:0]      St_mask;
    logic [31:0]     imm;
`ifdef RV32M_EN
    logic            Mext;
    logic [2:0]      mfunct;
`endif

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, rd, rs1, rs2,
               RegW, MemW, Jal, Jalr, illegal, Memtoreg, ALUa, ALUb,
               ALU_cntr, Branch_cntr, Ld_cntr, St_mask, imm
`ifdef RV32M_EN
      , output Mext, mfunct
`endif
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, rd, rs1, rs2,
               RegW, MemW, Jal, Jalr, illegal, Memtoreg, ALUa, ALUb,
               ALU_cntr, Branch_cntr, Ld_cntr, St_mask, imm
`ifdef RV32M_EN
      , input  Mext, mfunct
`endif
    );
endinterface

// File: rtl/instr_decode_stage.sv
// RV32I decode stage: instruction FIFO feeding a registered decoded-output stage.
// Define RV32M_EN to decode the M extension (Mext/mfunct outputs).
`timescale 1ns/1ps
module instr_decode_stage #(
    parameter int IQ_DEPTH = 4,
    parameter int PC_W     = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_decode_stage_if.slave bus
);
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef struct packed {
        logic [1:0]  memtoreg;
        logic [1:0]  alua;
        logic [1:0]  alub;
        logic        regw;
        logic        memw;
        logic        jal;
        logic        jalr;
        logic        illegal;
        logic [3:0]  alu_cntr;
        logic [2:0]  branch_cntr;
        logic [2:0]  ld_cntr;
        logic [3:0]  st_mask;
        logic [31:0] imm;
`ifdef RV32M_EN
        logic        mext;
        logic [2:0]  mfunct;
`endif
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t      c;
        logic [2:0] f3;
        logic [6:0] f7;
        c  = '0;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'b0000011: begin // load
                c.memtoreg = 2'b11; c.alua = 2'b11; c.alub = 2'b10;
                c.regw = 1'b1; c.alu_cntr = 4'b1000;
                c.imm = {{20{ins[31]}}, ins[31:20]};
                case (f3)
                    3'b010:  c.ld_cntr = 3'b000;
                    3'b001:  c.ld_cntr = 3'b001;
                    3'b000:  c.ld_cntr = 3'b010;
                    3'b101:  c.ld_cntr = 3'b101;
                    3'b100:  c.ld_cntr = 3'b110;
                    default: c.illegal = 1'b1;
                endcase
            end
            7'b0100011: begin // store
                c.memtoreg = 2'b00; c.alua = 2'b11; c.alub = 2'b10;
                c.memw = 1'b1; c.alu_cntr = 4'b1000;
                c.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                case (f3)
                    3'b010:  c.st_mask = 4'b1111;
                    3'b001:  c.st_mask = 4'b0011;
                    3'b000:  c.st_mask = 4'b0001;
                    default: c.illegal = 1'b1;
                endcase
            end
            7'b0110111: begin // lui
                c.memtoreg = 2'b01; c.alua = 2'b01; c.alub = 2'b10;
                c.regw = 1'b1; c.alu_cntr = 4'b1000;
                c.imm = {ins[31:12], 12'b0};
            end
            7'b0010111: begin // auipc
                c.memtoreg = 2'b01; c.alua = 2'b10; c.alub = 2'b10;
                c.regw = 1'b1; c.alu_cntr = 4'b1000;
                c.imm = {ins[31:12], 12'b0};
            end
            7'b0110011: begin // R-type
                c.memtoreg = 2'b01; c.alua = 2'b11; c.alub = 2'b00;
                c.regw = 1'b1;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000: c.alu_cntr = 4'b1000;
                            3'b001: begin c.alu_cntr = 4'b1101; c.alub = 2'b01; end
                            3'b010: begin c.alu_cntr = 4'b1100; c.memtoreg = 2'b10; end
                            3'b011: begin c.alu_cntr = 4'b0100; c.memtoreg = 2'b10; end
                            3'b100: c.alu_cntr = 4'b1010;
                            3'b101: begin c.alu_cntr = 4'b1110; c.alub = 2'b01; end
                            3'b110: c.alu_cntr = 4'b1011;
                            default: c.alu_cntr = 4'b1001;
                        endcase
                    end
                    7'b0100000: begin
                        if (f3 == 3'b000) begin
                            c.alu_cntr = 4'b1100;
                        end else if (f3 == 3'b101) begin
                            c.alu_cntr = 4'b1111; c.alub = 2'b01;
                        end else begin
                            c.illegal = 1'b1;
                        end
                    end
`ifdef RV32M_EN
                    7'b0000001: begin
                        c.mext = 1'b1; c.mfunct = f3;
                    end
`endif
                    default: c.illegal = 1'b1;
                endcase
            end
            7'b0010011: begin // OP-IMM
                c.memtoreg = 2'b01; c.alua = 2'b11; c.alub = 2'b10;
                c.regw = 1'b1;
                c.imm = {{20{ins[31]}}, ins[31:20]};
                case (f3)
                    3'b000: c.alu_cntr = 4'b1000;
                    3'b010: begin c.alu_cntr = 4'b1100; c.memtoreg = 2'b10; end
                    3'b011: begin c.alu_cntr = 4'b0100; c.memtoreg = 2'b10; end
                    3'b100: c.alu_cntr = 4'b1010;
                    3'b110: c.alu_cntr = 4'b1011;
                    3'b111: c.alu_cntr = 4'b1001;
                    3'b001: begin
                        c.alu_cntr = 4'b1101; c.imm = {27'b0, ins[24:20]};
                    end
                    default: begin
                        c.alu_cntr = ins[30] ? 4'b1111 : 4'b1110;
                        c.imm = {27'b0, ins[24:20]};
                    end
                endcase
            end
            7'b1100011: begin // branch
                c.memtoreg = 2'b01; c.alua = 2'b11; c.alub = 2'b00;
                c.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                case (f3)
                    3'b000: begin c.branch_cntr = 3'b001; c.alu_cntr = 4'b1100; end
                    3'b001: begin c.branch_cntr = 3'b010; c.alu_cntr = 4'b1100; end
                    3'b100: begin c.branch_cntr = 3'b011; c.alu_cntr = 4'b1100; end
                    3'b101: begin c.branch_cntr = 3'b100; c.alu_cntr = 4'b1100; end
                    3'b110: begin c.branch_cntr = 3'b011; c.alu_cntr = 4'b0100; end
                    3'b111: begin c.branch_cntr = 3'b100; c.alu_cntr = 4'b0100; end
                    default: c.illegal = 1'b1;
                endcase
            end
            7'b1101111: begin // jal
                c.memtoreg = 2'b01; c.alua = 2'b10; c.alub = 2'b11;
                c.regw = 1'b1; c.jal = 1'b1; c.alu_cntr = 4'b1000;
                c.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b1100111: begin // jalr
                c.memtoreg = 2'b01; c.alua = 2'b10; c.alub = 2'b11;
                c.regw = 1'b1; c.jalr = 1'b1; c.alu_cntr = 4'b1000;
                c.imm = {{20{ins[31]}}, ins[31:20]};
            end
            default: c.illegal = 1'b1;
        endcase
        // An illegal instruction carries no side effects downstream.
        if (c.illegal) begin
            c         = '0;
            c.illegal = 1'b1;
        end
        return c;
    endfunction

    logic [PC_W+31:0] mem_q [IQ_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic             ready_q;
    logic             out_valid_q;
    ctrl_t            ctrl_q;
    logic [PC_W-1:0]  pc_q;
    logic [4:0]       rd_q, rs1_q, rs2_q;

    logic             q_empty, q_full, load_out, accept, pop, bypass, push;
    logic [PC_W+31:0] head;
    logic [31:0]      sel_instr;
    logic [PC_W-1:0]  sel_pc;

    assign q_empty  = (wr_ptr_q == rd_ptr_q);
    assign q_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign load_out = !out_valid_q || bus.out_ready;
    // A full queue still accepts when the head is leaving in the same cycle.
    assign bus.in_ready = ready_q && !bus.flush && (!q_full || load_out);
    assign accept   = bus.in_valid && bus.in_ready;
    assign pop      = load_out && !q_empty && !bus.flush;
    assign bypass   = load_out && q_empty && accept;
    assign push     = accept && !bypass;
    assign head     = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign sel_instr = q_empty ? bus.in_instr : head[31:0];
    assign sel_pc    = q_empty ? bus.in_pc    : head[PC_W+31:32];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.in_pc, bus.in_instr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else begin
            ready_q <= 1'b1;
            if (bus.flush) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
                if (load_out) begin
                    out_valid_q <= pop || bypass;
                    if (pop || bypass) begin
                        ctrl_q <= decode(sel_instr);
                        pc_q   <= sel_pc;
                        rd_q   <= sel_instr[11:7];
                        rs1_q  <= sel_instr[19:15];
                        rs2_q  <= sel_instr[24:20];
                    end
                end
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = pc_q;
    assign bus.rd          = rd_q;
    assign bus.rs1         = rs1_q;
    assign bus.rs2         = rs2_q;
    assign bus.RegW        = ctrl_q.regw;
    assign bus.MemW        = ctrl_q.memw;
    assign bus.Jal         = ctrl_q.jal;
    assign bus.Jalr        = ctrl_q.jalr;
    assign bus.illegal     = ctrl_q.illegal;
    assign bus.Memtoreg    = ctrl_q.memtoreg;
    assign bus.ALUa        = ctrl_q.alua;
    assign bus.ALUb        = ctrl_q.alub;
    assign bus.ALU_cntr    = ctrl_q.alu_cntr;
    assign bus.Branch_cntr = ctrl_q.branch_cntr;
    assign bus.Ld_cntr     = ctrl_q.ld_cntr;
    assign bus.St_mask     = ctrl_q.st_mask;
    assign bus.imm         = ctrl_q.imm;
`ifdef RV32M_EN
    assign bus.Mext        = ctrl_q.mext;
    assign bus.mfunct      = ctrl_q.mfunct;
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage (default IQ_DEPTH=4, PC_W=32).
`timescale 1ns/1ps
module tb_instr_decode_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    instr_decode_stage_if #(.PC_W(32)) bus ();

    instr_decode_stage #(.IQ_DEPTH(4), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] addi_k(input int k);
        logic [31:0] w;
        w = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
        return w;
    endfunction

    task automatic dec(input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        cycle();
        bus.in_valid = 1'b0;
        $display("decode instr=0x%08h pc=0x%08h", ins, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_imm", bus.imm, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_rd", 32'(bus.rd), 0);
        chk("rst_regw", 32'(bus.RegW), 0);
        rst_n = 1'b1;
        #1 chk("rel_in_ready_low", 32'(bus.in_ready), 0);
        cycle();
        chk("rel_in_ready_high", 32'(bus.in_ready), 1);

        // addi x1,x0,5: one-cycle latency
        dec(32'h00500093, 32'h100);
        chk("addi_valid", 32'(bus.out_valid), 1);
        chk("addi_regw", 32'(bus.RegW), 1);
        chk("addi_alu", 32'(bus.ALU_cntr), 32'h8);
        chk("addi_imm", bus.imm, 5);
        chk("addi_rd", 32'(bus.rd), 1);
        chk("addi_pc", bus.out_pc, 32'h100);
        chk("addi_sel", 32'({bus.Memtoreg, bus.ALUa, bus.ALUb}), 32'b01_11_10);

        // sb then lhu back-to-back
        bus.in_valid = 1'b1; bus.in_instr = 32'h00208023; bus.in_pc = 32'h104;
        cycle();
        $display("decode instr=0x00208023 (sb)");
        chk("sb_mask", 32'(bus.St_mask), 32'b0001);
        chk("sb_memw", 32'(bus.MemW), 1);
        chk("sb_regw", 32'(bus.RegW), 0);
        chk("sb_sel", 32'({bus.Memtoreg, bus.ALUa, bus.ALUb}), 32'b00_11_10);
        bus.in_instr = 32'h0000D083; bus.in_pc = 32'h108;
        cycle();
        bus.in_valid = 1'b0;
        $display("decode instr=0x0000d083 (lhu)");
        chk("lhu_ld", 32'(bus.Ld_cntr), 32'b101);
        chk("lhu_regw", 32'(bus.RegW), 1);
        chk("lhu_memw", 32'(bus.MemW), 0);
        chk("lhu_mask", 32'(bus.St_mask), 0);
        chk("lhu_sel", 32'({bus.Memtoreg, bus.ALUa, bus.ALUb}), 32'b11_11_10);
        chk("lhu_pc", bus.out_pc, 32'h108);
        cycle();
        chk("drain_valid", 32'(bus.out_valid), 0);

        // back-pressure: fill output + queue, then full-queue push+pop
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.in_valid = 1'b1; bus.in_instr = addi_k(k); bus.in_pc = 32'(k * 4);
            #1 chk($sformatf("fill_in_ready_%0d", k), 32'(bus.in_ready), 1);
            cycle();
            $display("push addi x%0d,x0,%0d", k, k);
        end
        bus.in_valid = 1'b0;
        #1 chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("hold_rd", 32'(bus.rd), 1);
        cycle();
        chk("hold_rd2", 32'(bus.rd), 1);
        chk("hold_imm", bus.imm, 1);
        chk("hold_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        #1 chk("full_pushpop_ready", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.in_instr = addi_k(6); bus.in_pc = 32'(24);
        cycle();
        bus.in_valid = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            $display("pop expect addi x%0d", k);
            chk($sformatf("order_rd_%0d", k), 32'(bus.rd), 32'(k));
            chk($sformatf("order_pc_%0d", k), bus.out_pc, 32'(k * 4));
            chk($sformatf("order_valid_%0d", k), 32'(bus.out_valid), 1);
            cycle();
        end
        chk("order_empty", 32'(bus.out_valid), 0);

        // flush with 3 queued entries and a same-cycle push
        bus.out_ready = 1'b0;
        for (int k = 7; k <= 10; k++) begin
            bus.in_valid = 1'b1; bus.in_instr = addi_k(k); bus.in_pc = 32'(k * 4);
            cycle();
        end
        bus.in_instr = addi_k(11); bus.flush = 1'b1;
        #1 chk("flush_in_ready", 32'(bus.in_ready), 0);
        cycle();
        $display("flush with in_valid addi x11");
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        #1 chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_in_ready_back", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        chk("flush_empty", 32'(bus.out_valid), 0);
        dec(addi_k(12), 32'h30);
        chk("post_flush_rd", 32'(bus.rd), 12);
        cycle();
        chk("post_flush_drain", 32'(bus.out_valid), 0);

        // decode table and illegal cases
        dec(32'hFFFFFFFF, 32'h200);
        chk("ill_ff", 32'(bus.illegal), 1);
        chk("ill_ff_regw", 32'(bus.RegW), 0);
        chk("ill_ff_memw", 32'(bus.MemW), 0);
        chk("ill_ff_br", 32'(bus.Branch_cntr), 0);
        dec(32'h00002063, 32'h204);
        chk("ill_br", 32'(bus.illegal), 1);
        chk("ill_br_cntr", 32'(bus.Branch_cntr), 0);
        chk("ill_br_regw", 32'(bus.RegW), 0);
        dec(32'h00209463, 32'h208);
        chk("bne_ill", 32'(bus.illegal), 0);
        chk("bne_br", 32'(bus.Branch_cntr), 32'b010);
        chk("bne_alu", 32'(bus.ALU_cntr), 32'b1100);
        chk("bne_imm", bus.imm, 8);
        chk("bne_sel", 32'({bus.Memtoreg, bus.ALUa, bus.ALUb}), 32'b01_11_00);
        dec(32'hFFF00093, 32'h20C);
        chk("addi_neg_imm", bus.imm, 32'hFFFFFFFF);
        dec(32'h402081B3, 32'h210);
        chk("sub_alu", 32'(bus.ALU_cntr), 32'b1100);
        chk("sub_sel", 32'({bus.Memtoreg, bus.ALUa, bus.ALUb}), 32'b01_11_00);
        chk("sub_rs2", 32'(bus.rs2), 2);
        dec(32'h0020A1B3, 32'h214);
        chk("slt_m2r", 32'(bus.Memtoreg), 32'b10);
        chk("slt_alu", 32'(bus.ALU_cntr), 32'b1100);
        dec(32'h12345037, 32'h218);
        chk("lui_imm", bus.imm, 32'h12345000);
        chk("lui_sel", 32'({bus.Memtoreg, bus.ALUa, bus.ALUb}), 32'b01_01_10);
        dec(32'h01F09093, 32'h21C);
        chk("slli_imm", bus.imm, 31);
        chk("slli_alu", 32'(bus.ALU_cntr), 32'b1101);
        dec(32'hFFDFF0EF, 32'h220);
        chk("jal_imm", bus.imm, 32'hFFFFFFFC);
        chk("jal_flag", 32'(bus.Jal), 1);
        chk("jal_sel", 32'({bus.Memtoreg, bus.ALUa, bus.ALUb}), 32'b01_10_11);
        dec(32'hFE20AC23, 32'h224);
        chk("sw_imm", bus.imm, 32'hFFFFFFF8);
        chk("sw_mask", 32'(bus.St_mask), 32'b1111);
        dec(32'h022081B3, 32'h228);
`ifdef RV32M_EN
        chk("mul_ill", 32'(bus.illegal), 0);
        chk("mul_mext", 32'(bus.Mext), 1);
        chk("mul_mfunct", 32'(bus.mfunct), 0);
        chk("mul_regw", 32'(bus.RegW), 1);
`else
        chk("mul_ill", 32'(bus.illegal), 1);
        chk("mul_regw", 32'(bus.RegW), 0);
`endif
        cycle();

        // reset asserted with contents queued
        bus.out_ready = 1'b0;
        for (int k = 13; k <= 14; k++) begin
            bus.in_valid = 1'b1; bus.in_instr = addi_k(k); bus.in_pc = 32'(k * 4);
            cycle();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        $display("reset asserted mid-transfer");
        #1 chk("mrst_valid", 32'(bus.out_valid), 0);
        chk("mrst_in_ready", 32'(bus.in_ready), 0);
        chk("mrst_imm", bus.imm, 0);
        chk("mrst_rd", 32'(bus.rd), 0);
        chk("mrst_pc", bus.out_pc, 0);
        cycle();
        rst_n = 1'b1;
        #1 chk("mrst_rel_low", 32'(bus.in_ready), 0);
        cycle();
        chk("mrst_rel_high", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        cycle();
        chk("mrst_discarded", 32'(bus.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
